decode: RTL and testbench

Second pipeline stage of the RS5 core. Consumes the fetched instruction word, its PC and the kill flag from the fetch stage, then:
- decodes RV32I into an operation class, register indices and a sign-extended immediate;
- detects load-use hazards and raises `hazard_o` back to fetch;
- registers everything for the execute stage.

Killed or flushed slots leave the stage as bubbles.

---
 rtl/RS5_pkg.sv | 35 +++
 rtl/immediate_gen.sv | 38 +++
 rtl/decode.sv | 202 ++++++++++++++++++++
 tb/tb_decode.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/RS5_pkg.sv
// Shared RS5 definitions: operation enum, RV32I opcodes and immediate formats.
package RS5_pkg;

  typedef enum logic [5:0] {
    NOP, INVALID, LUI, ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA,
    BEQ, BNE, BLT, BLTU, BGE, BGEU, JAL, JALR,
    LB, LBU, LH, LHU, LW, SB, SH, SW,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
    ECALL, EBREAK, MRET, WFI
  } iType_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
  localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
  localparam logic [31:0] WORD_MRET   = 32'h3020_0073;
  localparam logic [31:0] WORD_WFI    = 32'h1050_0073;

  function automatic logic is_load(input iType_e op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

endpackage

// File: rtl/immediate_gen.sv
// Selects the RV32I immediate format from the opcode and sign-extends from instr[31].
module immediate_gen
  import RS5_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] imm
);

  imm_fmt_e fmt;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    fmt = IMM_NONE;
    case (instruction[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
      OPC_STORE:                                  fmt = IMM_S;
      OPC_BRANCH:                                 fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
      OPC_JAL:                                    fmt = IMM_J;
      default:                                    fmt = IMM_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      IMM_U: imm = {instruction[31:12], 12'b0};
      IMM_J: imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RS5 decode stage: RV32I decode, load-use hazard detection with a one-slot
// hold register, and the decode/execute pipeline registers.
module decode
  import RS5_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction_i,
  input  logic [31:0] pc_i,
  input  logic        killed_i,
  input  logic        flush_i,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        hazard_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_q_o,
  output logic [4:0]  rs2_q_o,
  output logic [31:0] imm_o,
  output iType_e      operation_o,
  output logic        killed_o,
  output logic        exc_illegal_o,
  output logic        exc_misaligned_o,
  output logic        exc_ecall_o,
  output logic        exc_ebreak_o
);

  logic        hold_valid;
  logic [31:0] hold_instr, hold_pc;
  logic        last_is_load;
  logic [4:0]  last_load_rd;

  logic [31:0] src_instr, src_pc, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        misaligned, bubble;
  iType_e      op;

  assign src_instr = hold_valid ? hold_instr : instruction_i;
  assign src_pc    = hold_valid ? hold_pc    : pc_i;
  assign opcode    = src_instr[6:0];
  assign funct3    = src_instr[14:12];
  assign funct7    = src_instr[31:25];

  assign rs1_o = (opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL}) ? 5'd0 : src_instr[19:15];
  assign rs2_o = (opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH}) ? src_instr[24:20] : 5'd0;
  assign rd    = (opcode inside {OPC_STORE, OPC_BRANCH}) ? 5'd0 : src_instr[11:7];

  immediate_gen u_immediate_gen (
    .instruction (src_instr),
    .imm         (imm)
  );

  always_comb begin
    op = INVALID;
    case (opcode)
      OPC_LUI:      op = LUI;
      OPC_AUIPC:    op = ADD;
      OPC_JAL:      op = JAL;
      OPC_JALR:     if (funct3 == 3'b000) op = JALR;
      OPC_MISC_MEM: op = NOP;
      OPC_BRANCH:
        case (funct3)
          3'b000: op = BEQ;
          3'b001: op = BNE;
          3'b100: op = BLT;
          3'b101: op = BGE;
          3'b110: op = BLTU;
          3'b111: op = BGEU;
          default: op = INVALID;
        endcase
      OPC_LOAD:
        case (funct3)
          3'b000: op = LB;
          3'b001: op = LH;
          3'b010: op = LW;
          3'b100: op = LBU;
          3'b101: op = LHU;
          default: op = INVALID;
        endcase
      OPC_STORE:
        case (funct3)
          3'b000: op = SB;
          3'b001: op = SH;
          3'b010: op = SW;
          default: op = INVALID;
        endcase
      OPC_OP_IMM:
        case (funct3)
          3'b000: op = ADD;
          3'b010: op = SLT;
          3'b011: op = SLTU;
          3'b100: op = XOR;
          3'b110: op = OR;
          3'b111: op = AND;
          3'b001: if (funct7 == 7'b0000000) op = SLL;
          default: begin
            // funct3 101: imm[10] (funct7 bit 5) picks arithmetic vs logical shift
            if (funct7 == 7'b0000000)      op = SRL;
            else if (funct7 == 7'b0100000) op = SRA;
          end
        endcase
      OPC_OP:
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: op = ADD;
            3'b001: op = SLL;
            3'b010: op = SLT;
            3'b011: op = SLTU;
            3'b100: op = XOR;
            3'b101: op = SRL;
            3'b110: op = OR;
            default: op = AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      op = SUB;
          else if (funct3 == 3'b101) op = SRA;
        end
      OPC_SYSTEM:
        case (funct3)
          3'b000:
            if (src_instr == WORD_ECALL)       op = ECALL;
            else if (src_instr == WORD_EBREAK) op = EBREAK;
            else if (src_instr == WORD_MRET)   op = MRET;
            else if (src_instr == WORD_WFI)    op = WFI;
          3'b001: op = CSRRW;
          3'b010: op = CSRRS;
          3'b011: op = CSRRC;
          3'b101: op = CSRRWI;
          3'b110: op = CSRRSI;
          3'b111: op = CSRRCI;
          default: op = INVALID;
        endcase
      default: op = INVALID;
    endcase
  end

  assign hazard_o = last_is_load && (last_load_rd != 5'd0)
                  && ((last_load_rd == rs1_o) || (last_load_rd == rs2_o)) && !killed_o;

  assign misaligned = (src_pc[1:0] != 2'b00);
  assign bubble     = flush_i || killed_i || hazard_o;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      pc_o             <= '0;
      rd_o             <= '0;
      rs1_q_o          <= '0;
      rs2_q_o          <= '0;
      imm_o            <= '0;
      operation_o      <= NOP;
      killed_o         <= 1'b1;
      exc_illegal_o    <= 1'b0;
      exc_misaligned_o <= 1'b0;
      exc_ecall_o      <= 1'b0;
      exc_ebreak_o     <= 1'b0;
      hold_valid       <= 1'b0;
      last_is_load     <= 1'b0;
    end else if (!stall) begin
      pc_o    <= src_pc;
      rs1_q_o <= rs1_o;
      rs2_q_o <= rs2_o;
      imm_o   <= imm;
      // Only a genuine hazard parks the slot; flush or kill drops any held copy.
      hold_valid <= hazard_o && !flush_i && !killed_i;
      if (bubble) begin
        operation_o      <= NOP;
        killed_o         <= 1'b1;
        rd_o             <= '0;
        exc_illegal_o    <= 1'b0;
        exc_misaligned_o <= 1'b0;
        exc_ecall_o      <= 1'b0;
        exc_ebreak_o     <= 1'b0;
        last_is_load     <= 1'b0;
      end else begin
        operation_o      <= op;
        killed_o         <= 1'b0;
        rd_o             <= rd;
        exc_illegal_o    <= (op == INVALID) && !misaligned;
        exc_misaligned_o <= misaligned;
        exc_ecall_o      <= (op == ECALL);
        exc_ebreak_o     <= (op == EBREAK);
        last_is_load     <= is_load(op);
      end
    end
  end

  // NOTE: pure datapath registers stay out of reset; their valid bits (hold_valid, last_is_load) gate every use.
  always_ff @(posedge clk) begin
    if (!stall) begin
      last_load_rd <= rd;
      if (hazard_o) begin
        hold_instr <= src_instr;
        hold_pc    <= src_pc;
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: expected register outputs go into a scoreboard
// queue when an input slot is driven and are compared one clock later.
module tb_decode;
  import RS5_pkg::*;

  logic        clk, reset, stall, killed_i, flush_i;
  logic [31:0] instruction_i, pc_i;
  logic [4:0]  rs1_o, rs2_o, rd_o, rs1_q_o, rs2_q_o;
  logic        hazard_o, killed_o;
  logic [31:0] pc_o, imm_o;
  iType_e      operation_o;
  logic        exc_illegal_o, exc_misaligned_o, exc_ecall_o, exc_ebreak_o;

  decode dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .instruction_i    (instruction_i),
    .pc_i             (pc_i),
    .killed_i         (killed_i),
    .flush_i          (flush_i),
    .rs1_o            (rs1_o),
    .rs2_o            (rs2_o),
    .hazard_o         (hazard_o),
    .pc_o             (pc_o),
    .rd_o             (rd_o),
    .rs1_q_o          (rs1_q_o),
    .rs2_q_o          (rs2_q_o),
    .imm_o            (imm_o),
    .operation_o      (operation_o),
    .killed_o         (killed_o),
    .exc_illegal_o    (exc_illegal_o),
    .exc_misaligned_o (exc_misaligned_o),
    .exc_ecall_o      (exc_ecall_o),
    .exc_ebreak_o     (exc_ebreak_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    iType_e      op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        killed, ill, mis, ecall, full;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LW_X2   = 32'h0000_A103;  // lw x2,0(x1)
  localparam logic [31:0] I_ADD_X3  = 32'h0021_01B3;  // add x3,x2,x2
  localparam logic [31:0] I_ALLONES = 32'hFFFF_FFFF;
  localparam logic [31:0] I_SRAI    = 32'h4030_D213;  // srai x4,x1,3
  localparam logic [31:0] I_SW      = 32'h0020_A423;  // sw x2,8(x1)
  localparam logic [31:0] I_ECALL   = 32'h0000_0073;
  localparam logic [31:0] I_LW_X5   = 32'h0040_2283;  // lw x5,4(x0)
  localparam logic [31:0] I_ADD_X6  = 32'h0002_8333;  // add x6,x5,x0
  localparam logic [31:0] I_ADDI_X7 = 32'h0070_0393;  // addi x7,x0,7
  localparam logic [31:0] I_BEQ     = 32'hFE20_8EE3;  // beq x1,x2,-4

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                       input logic r, input logic k, input logic f, input logic s);
    instruction_i = ins;
    pc_i          = p;
    reset         = r;
    killed_i      = k;
    flush_i       = f;
    stall         = s;
    #1;
  endtask

  task automatic push(input iType_e op, input logic [4:0] rd, input logic [31:0] imm,
                      input logic [31:0] p, input logic killed, input logic ill,
                      input logic mis, input logic ecall, input logic full);
    exp_t e;
    e.op = op; e.rd = rd; e.imm = imm; e.pc = p;
    e.killed = killed; e.ill = ill; e.mis = mis; e.ecall = ecall; e.full = full;
    sb.push_back(e);
  endtask

  task automatic push_bubble();
    push(NOP, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".op"},     32'(operation_o),      32'(e.op));
    check({tag, ".killed"}, 32'(killed_o),         32'(e.killed));
    check({tag, ".rd"},     32'(rd_o),             32'(e.rd));
    check({tag, ".ill"},    32'(exc_illegal_o),    32'(e.ill));
    check({tag, ".mis"},    32'(exc_misaligned_o), 32'(e.mis));
    check({tag, ".ecall"},  32'(exc_ecall_o),      32'(e.ecall));
    if (e.full) begin
      check({tag, ".imm"}, imm_o, e.imm);
      check({tag, ".pc"},  pc_o,  e.pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset wins over a valid instruction on the inputs.
    drive(I_ADDI_X1, 32'h100, 1, 0, 0, 0);
    push(NOP, 0, 0, 0, 1, 0, 0, 0, 1);
    tick("reset");

    drive(I_ADDI_X1, 32'h100, 0, 0, 0, 0);
    check("addi.hazard", 32'(hazard_o), 0);
    check("addi.rs2", 32'(rs2_o), 0);
    push(ADD, 1, 32'd5, 32'h100, 0, 0, 0, 0, 1);
    tick("addi");

    // Load-use pair: one bubble, then the held ADD.
    drive(I_LW_X2, 32'h104, 0, 0, 0, 0);
    check("lw.rs1", 32'(rs1_o), 1);
    check("lw.hazard", 32'(hazard_o), 0);
    push(LW, 2, 32'd0, 32'h104, 0, 0, 0, 0, 1);
    tick("lw");

    drive(I_ADD_X3, 32'h108, 0, 0, 0, 0);
    check("use.hazard", 32'(hazard_o), 1);
    check("use.rs2", 32'(rs2_o), 2);
    push_bubble();
    tick("use.bubble");

    drive(I_ALLONES, 32'h10C, 0, 0, 0, 0);
    check("held.hazard", 32'(hazard_o), 0);
    check("held.rs1", 32'(rs1_o), 2);
    push(ADD, 3, 32'd0, 32'h108, 0, 0, 0, 0, 1);
    tick("held.add");

    drive(I_ALLONES, 32'h10C, 0, 0, 0, 0);
    push(INVALID, 31, 0, 0, 0, 1, 0, 0, 0);
    tick("illegal");

    drive(I_ALLONES, 32'h102, 0, 0, 0, 0);
    push(INVALID, 31, 0, 0, 0, 0, 1, 0, 0);
    tick("misaligned");

    drive(I_SRAI, 32'h110, 0, 0, 0, 0);
    push(SRA, 4, 32'h403, 32'h110, 0, 0, 0, 0, 1);
    tick("srai");

    drive(I_SW, 32'h114, 0, 0, 0, 0);
    check("sw.rs2", 32'(rs2_o), 2);
    push(SW, 0, 32'd8, 32'h114, 0, 0, 0, 0, 1);
    tick("sw");

    drive(I_ECALL, 32'h118, 0, 0, 0, 0);
    push(ECALL, 0, 32'd0, 32'h118, 0, 0, 0, 1, 1);
    tick("ecall");

    // Flush while a hazard copy is held: held slot is dropped.
    drive(I_LW_X5, 32'h200, 0, 0, 0, 0);
    push(LW, 5, 32'd4, 32'h200, 0, 0, 0, 0, 1);
    tick("lw5");

    drive(I_ADD_X6, 32'h204, 0, 0, 0, 0);
    check("use5.hazard", 32'(hazard_o), 1);
    push_bubble();
    tick("use5.bubble");

    drive(I_ADDI_X7, 32'h300, 0, 0, 1, 0);
    check("flush.rs1", 32'(rs1_o), 5);
    push_bubble();
    tick("flush");

    drive(I_ADDI_X7, 32'h300, 0, 0, 0, 0);
    check("postflush.hazard", 32'(hazard_o), 0);
    check("postflush.rs1", 32'(rs1_o), 0);
    push(ADD, 7, 32'd7, 32'h300, 0, 0, 0, 0, 1);
    tick("postflush");

    // Stall freezes the registered outputs for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(I_BEQ, 32'h400, 0, 0, 0, 1);
      check("stall.rs1", 32'(rs1_o), 1);
      check("stall.rs2", 32'(rs2_o), 2);
      push(ADD, 7, 32'd7, 32'h300, 0, 0, 0, 0, 1);
      tick("stall");
    end
    drive(I_BEQ, 32'h400, 0, 0, 0, 0);
    push(BEQ, 0, 32'hFFFF_FFFC, 32'h400, 0, 0, 0, 0, 1);
    tick("beq");

    // Reset while a hazard copy is held discards it.
    drive(I_LW_X2, 32'h500, 0, 0, 0, 0);
    push(LW, 2, 32'd0, 32'h500, 0, 0, 0, 0, 1);
    tick("lw.b");

    drive(I_ADD_X3, 32'h504, 0, 0, 0, 0);
    check("use.b.hazard", 32'(hazard_o), 1);
    push_bubble();
    tick("use.b.bubble");

    drive(I_ADD_X3, 32'h504, 1, 0, 0, 0);
    push(NOP, 0, 0, 0, 1, 0, 0, 0, 1);
    tick("reset.hold");

    drive(I_ADDI_X1, 32'h600, 0, 0, 0, 0);
    check("postreset.hazard", 32'(hazard_o), 0);
    check("postreset.rs1", 32'(rs1_o), 0);
    push(ADD, 1, 32'd5, 32'h600, 0, 0, 0, 0, 1);
    tick("postreset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
